systolic_skew_buffer: RTL and testbench

//   Parametrised multi-lane registered delay line feeding the edge of the systolic array.

---
 rtl/systolic_pkg.sv | 13 +
 rtl/systolic_skew_buffer_delay_line.sv | 43 ++++
 rtl/systolic_skew_buffer.sv | 42 ++++
 tb/tb_systolic_skew_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic array edge logic.
// skew_dly() is the single source of truth for per-lane skew depth.
package systolic_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    function automatic int skew_dly(input int i, input int step);
        return 1 + i * step;
    endfunction

endpackage

// File: rtl/systolic_skew_buffer_delay_line.sv
// One lane of the skew buffer: DEPTH registered {valid,data} stages with
// global hold and synchronous clear.
module delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

    // Data moves with valid unconditionally so the shift is a plain register chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= in_valid;
            dat_pipe[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat_pipe[DEPTH-1];
    assign any_valid = |vld_pipe;

endmodule

// File: rtl/systolic_skew_buffer.sv
// Skews a lane vector into diagonal wavefront order for the PE array edge:
// lane i is delayed by skew_dly(i, STEP) cycles.
module systolic_skew_buffer
    import systolic_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int LANES = 4,
    parameter int STEP  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   drained
);

    logic [LANES-1:0] any_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (skew_dly(i, STEP))
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .stall     (stall),
            .flush     (flush),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[i*WIDTH +: WIDTH]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .any_valid (any_valid[i])
        );
    end

    assign drained = ~|any_valid;

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Directed bench for systolic_skew_buffer at WIDTH=32, LANES=4, STEP=1.
module tb_systolic_skew_buffer;
    import systolic_pkg::*;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int STEP  = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   stall;
    logic                   flush;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   drained;

    int n_chk = 0;
    int n_err = 0;

    systolic_skew_buffer #(.WIDTH(WIDTH), .LANES(LANES), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drained   (drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_data(input int i);
        return out_data[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_all(input logic [31:0] base, input logic add_idx);
        for (int i = 0; i < LANES; i++)
            in_data[i*WIDTH +: WIDTH] = add_idx ? base + 32'(i) : base;
    endtask

    // Vector A0+i was captured; 'shifts' un-stalled edges have occurred since (incl. capture).
    task automatic check_vec(input string tag, input int shifts);
        for (int i = 0; i < LANES; i++) begin
            logic ev;
            ev = (shifts == skew_dly(i, STEP));
            chk($sformatf("%s s%0d v%0d", tag, shifts, i), 32'(out_valid[i]), 32'(ev));
            if (ev) chk($sformatf("%s s%0d d%0d", tag, shifts, i), lane_data(i), 32'hA0 + 32'(i));
        end
        chk($sformatf("%s s%0d drained", tag, shifts), 32'(drained),
            32'(shifts > skew_dly(LANES-1, STEP)));
    endtask

    task automatic skew_run(input string tag);
        in_valid = '1;
        set_all(32'hA0, 1'b1);
        step();
        in_valid = '0;
        set_all(32'hDEAD, 1'b0);
        check_vec(tag, 1);
        for (int s = 2; s <= 6; s++) begin
            step();
            check_vec(tag, s);
        end
    endtask

    initial begin
        int shifts;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0;

        // 1: reset holds outputs cleared regardless of inputs
        for (int c = 0; c < 3; c++) begin
            in_valid = 4'($urandom);
            stall = 1'($urandom);
            for (int i = 0; i < LANES; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
            step();
            chk("rst valid", 32'(out_valid), 32'h0);
            chk("rst data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'h0);
            chk("rst drained", 32'(drained), 32'h1);
        end
        in_valid = '0; stall = 1'b0; in_data = '0;
        rst = 1'b1;
        step(); step();
        chk("idle valid", 32'(out_valid), 32'h0);
        chk("idle drained", 32'(drained), 32'h1);

        // 2: basic skew
        skew_run("skew");

        // 3: streaming at full throughput
        for (int e = 0; e < 12; e++) begin
            in_valid = (e < 8) ? '1 : '0;
            set_all(32'(e), 1'b0);
            step();
            for (int i = 0; i < LANES; i++) begin
                int k;
                logic ev;
                k = e - i;
                ev = (k >= 0 && k < 8);
                chk($sformatf("strm e%0d v%0d", e, i), 32'(out_valid[i]), 32'(ev));
                if (ev) chk($sformatf("strm e%0d d%0d", e, i), lane_data(i), 32'(k));
            end
            chk($sformatf("strm e%0d drained", e), 32'(drained), 32'(e >= 11));
        end

        // 4: stall on the three edges after capture; stalled inputs must be ignored
        in_valid = '1;
        set_all(32'hA0, 1'b1);
        step();
        shifts = 1;
        check_vec("stall", shifts);
        for (int c = 1; c <= 8; c++) begin
            stall = (c <= 3);
            in_valid = stall ? '1 : '0;
            set_all(stall ? 32'hBAD0 : 32'hDEAD, 1'b0);
            step();
            if (!stall) shifts++;
            check_vec("stall", shifts);
        end
        stall = 1'b0;

        // 5: flush wins over stall and drops the presented inputs
        in_valid = '1;
        set_all(32'hA0, 1'b1);
        step();
        in_valid = '0;
        step();
        flush = 1'b1; stall = 1'b1; in_valid = '1;
        set_all(32'h5555, 1'b0);
        step();
        flush = 1'b0; stall = 1'b0; in_valid = '0;
        chk("flush valid", 32'(out_valid), 32'h0);
        chk("flush data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'h0);
        chk("flush drained", 32'(drained), 32'h1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("post flush v%0d", c), 32'(out_valid), 32'h0);
            chk($sformatf("post flush dr%0d", c), 32'(drained), 32'h1);
        end

        // 6: async reset mid-stream clears outputs before the next edge
        in_valid = '1;
        for (int e = 0; e < 4; e++) begin
            set_all(32'(e + 100), 1'b0);
            step();
        end
        chk("pre arst drained", 32'(drained), 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("arst valid", 32'(out_valid), 32'h0);
        chk("arst data", out_data[31:0] | out_data[63:32] | out_data[95:64] | out_data[127:96], 32'h0);
        chk("arst drained", 32'(drained), 32'h1);
        in_valid = '0;
        #1 rst = 1'b1;
        step();
        skew_run("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
